// File: rtl/nec_ir_tx_pkg.sv
// Shared NEC IR definitions: state encodings, unit-count constants, mark decode.
// Optional macro NEC_IR_TX_REPEAT_EN adds the repeat-code states.
package nec_ir_tx_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_GAP
`ifdef NEC_IR_TX_REPEAT_EN
        , S_REP_MARK,
        S_REP_SPACE,
        S_REP_STOP
`endif
    } state_t;

    localparam int LEAD_MARK_U  = 16;
    localparam int LEAD_SPACE_U = 8;
    localparam int BIT0_SPACE_U = 1;
    localparam int BIT1_SPACE_U = 3;
    localparam int REP_MARK_U   = 16;
    localparam int REP_SPACE_U  = 4;
    localparam int ACTIVE_U     = 121;

    // A state drives the LED envelope high when it is one of the mark states.
    function automatic logic is_mark(input state_t s);
        case (s)
            S_LEAD_MARK, S_BIT_MARK, S_STOP_MARK: is_mark = 1'b1;
`ifdef NEC_IR_TX_REPEAT_EN
            S_REP_MARK, S_REP_STOP:               is_mark = 1'b1;
`endif
            default:                              is_mark = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/nec_ir_tx_carrier.sv
// Carrier generator: 50% square wave, phase-restarted high at each mark entry.
module ir_carrier_gen #(
    parameter int CARRIER_HALF = 658
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic carrier
);
    localparam int CW = $clog2(CARRIER_HALF + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CARRIER_HALF - 1);

    logic [CW-1:0] cnt;

    // Restart loads the high phase so the first mark cycle is lit; idle holds low.
    always_ff @(posedge clk) begin
        if (rst || (!restart && !enable)) begin
            cnt     <= '0;
            carrier <= 1'b0;
        end else if (restart) begin
            cnt     <= '0;
            carrier <= 1'b1;
        end else if (cnt == HALF_LAST) begin
            cnt     <= '0;
            carrier <= ~carrier;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/nec_ir_tx.sv
// NEC IR transmitter: frames addr/~addr/cmd/~cmd with leader and stop mark,
// pads each frame to FRAME_UNITS. Optional macro NEC_IR_TX_REPEAT_EN sends
// repeat codes while tx_repeat stays high.
module nec_ir_tx
    import nec_ir_tx_pkg::*;
#(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_HALF = 658,
    parameter int FRAME_UNITS  = 192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_addr,
    input  logic [7:0] tx_cmd,
    input  logic       tx_start,
    input  logic       tx_repeat,
    output logic       tx_ready,
    output logic       frame_done,
    output logic       ir_env,
    output logic       ir_out
);
    localparam int TW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [TW-1:0] UNIT_LAST  = TW'(UNIT_CYCLES - 1);
    localparam logic [7:0]    FRAME_LAST = 8'(FRAME_UNITS - 1);

    state_t        state, nxt, after_gap;
    logic [TW-1:0] timer;
    logic [4:0]    ucnt;
    logic [7:0]    frame_cnt;
    logic [4:0]    bit_idx;
    logic [31:0]   shreg;
    logic          tick, frame_end, accept, period_start, restart, carrier;

    assign tick      = (timer == UNIT_LAST);
    assign frame_end = tick && (frame_cnt == FRAME_LAST);

`ifdef NEC_IR_TX_REPEAT_EN
    assign after_gap    = tx_repeat ? S_REP_MARK : S_IDLE;
    assign period_start = accept || (state != S_REP_MARK && nxt == S_REP_MARK);
`else
    logic unused_repeat;
    assign unused_repeat = tx_repeat;
    assign after_gap     = S_IDLE;
    assign period_start  = accept;
`endif

    // Next-state: every timed transition waits for the last tick of its unit count.
    always_comb begin
        nxt        = state;
        accept     = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE:       if (tx_start) begin accept = 1'b1; nxt = S_LEAD_MARK; end
            S_LEAD_MARK:  if (tick && ucnt == 5'(LEAD_MARK_U - 1)) nxt = S_LEAD_SPACE;
            S_LEAD_SPACE: if (tick && ucnt == 5'(LEAD_SPACE_U - 1)) nxt = S_BIT_MARK;
            S_BIT_MARK:   if (tick) nxt = S_BIT_SPACE;
            S_BIT_SPACE:
                if (tick && ucnt == (shreg[0] ? 5'(BIT1_SPACE_U - 1) : 5'(BIT0_SPACE_U - 1)))
                    nxt = (bit_idx == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
            S_STOP_MARK:
                if (tick) begin
                    frame_done = 1'b1;
                    nxt        = frame_end ? after_gap : S_GAP;
                end
            S_GAP:        if (frame_end) nxt = after_gap;
`ifdef NEC_IR_TX_REPEAT_EN
            S_REP_MARK:   if (tick && ucnt == 5'(REP_MARK_U - 1)) nxt = S_REP_SPACE;
            S_REP_SPACE:  if (tick && ucnt == 5'(REP_SPACE_U - 1)) nxt = S_REP_STOP;
            S_REP_STOP:
                if (tick) begin
                    frame_done = 1'b1;
                    nxt        = frame_end ? after_gap : S_GAP;
                end
`endif
            default:      nxt = S_IDLE;
        endcase
    end

    // State, unit timer, per-state unit count, frame-period count and payload shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            ucnt      <= '0;
            frame_cnt <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
        end else begin
            state <= nxt;

            if (state == S_IDLE || tick) timer <= '0;
            else                         timer <= timer + 1'b1;

            if (nxt != state) ucnt <= '0;
            else if (tick)    ucnt <= ucnt + 1'b1;

            if (period_start)                   frame_cnt <= '0;
            else if (tick && state != S_IDLE)   frame_cnt <= frame_cnt + 1'b1;

            if (accept) begin
                shreg   <= {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
                bit_idx <= '0;
            end else if (state == S_BIT_SPACE && nxt != S_BIT_SPACE) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    assign restart  = is_mark(nxt) && (nxt != state);
    assign ir_env   = is_mark(state);
    assign tx_ready = (state == S_IDLE);
    assign ir_out   = ir_env & carrier;

    ir_carrier_gen #(.CARRIER_HALF(CARRIER_HALF)) u_carrier (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .enable  (ir_env),
        .carrier (carrier)
    );
endmodule

// File: tb/tb_nec_ir_tx.sv
// Bench for nec_ir_tx: random frames against a segment-list timing model.
module tb_nec_ir_tx;
    localparam int U   = 4;
    localparam int CH  = 1;
    localparam int FU  = 192;
    localparam int PER = FU * U;
    localparam int MAXC = 3 * PER + 2;

    logic       clk = 1'b0;
    logic       rst, tx_start, tx_repeat;
    logic [7:0] tx_addr, tx_cmd;
    logic       tx_ready, frame_done, ir_env, ir_out;

    int total = 0;
    int bad   = 0;

    logic env_m  [0:MAXC];
    logic done_m [0:MAXC];

    always #5 clk = ~clk;

    nec_ir_tx #(.UNIT_CYCLES(U), .CARRIER_HALF(CH), .FRAME_UNITS(FU)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_addr    (tx_addr),
        .tx_cmd     (tx_cmd),
        .tx_start   (tx_start),
        .tx_repeat  (tx_repeat),
        .tx_ready   (tx_ready),
        .frame_done (frame_done),
        .ir_env     (ir_env),
        .ir_out     (ir_out)
    );

    task automatic chk(input string tag, input logic obs, input logic exp, input int cyc);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d got=%b want=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic seg(inout int pos, input logic lvl, input int units);
        for (int k = 0; k < units * U; k++) begin
            env_m[pos] = lvl;
            pos++;
        end
    endtask

    // Expected envelope and frame_done per cycle, cycle 1 = first cycle after accept.
    task automatic build(input logic [7:0] a, input logic [7:0] c, input int nper);
        int pos;
        logic [31:0] w;
        for (int k = 0; k <= MAXC; k++) begin
            env_m[k]  = 1'b0;
            done_m[k] = 1'b0;
        end
        w   = {~c, c, ~a, a};
        pos = 1;
        seg(pos, 1'b1, 16);
        seg(pos, 1'b0, 8);
        for (int i = 0; i < 32; i++) begin
            seg(pos, 1'b1, 1);
            seg(pos, 1'b0, w[i] ? 3 : 1);
        end
        seg(pos, 1'b1, 1);
        done_m[pos-1] = 1'b1;
        for (int p = 1; p < nper; p++) begin
            pos = p * PER + 1;
            seg(pos, 1'b1, 16);
            seg(pos, 1'b0, 4);
            seg(pos, 1'b1, 1);
            done_m[pos-1] = 1'b1;
        end
    endtask

    // Presents a start in the current cycle and checks ncyc cycles after acceptance.
    task automatic run(input logic [7:0] a, input logic [7:0] c, input int nper,
                       input int ncyc, input bit inject);
        int   moff;
        logic exp_out;
        build(a, c, nper);
        chk("ready_pre", tx_ready, 1'b1, 0);
        tx_addr  = a;
        tx_cmd   = c;
        tx_start = 1'b1;
        moff     = 0;
        for (int cy = 1; cy <= ncyc; cy++) begin
            @(posedge clk);
            #1;
            if (cy == 1) begin
                tx_start = 1'b0;
                tx_addr  = 8'($urandom);
                tx_cmd   = 8'($urandom);
            end
            exp_out = env_m[cy] && (((moff / CH) % 2) == 0);
            chk("env",   ir_env,     env_m[cy],          cy);
            chk("out",   ir_out,     exp_out,            cy);
            chk("done",  frame_done, done_m[cy],         cy);
            chk("ready", tx_ready,   (cy > nper * PER),  cy);
            if (env_m[cy]) moff++;
            else           moff = 0;
            if (inject && cy == 200) begin
                tx_start = 1'b1;
                tx_addr  = 8'hFF;
            end
            if (inject && cy == 201) tx_start = 1'b0;
            if (nper > 1 && cy == PER + 300) tx_repeat = 1'b0;
        end
    endtask

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        tx_start  = 1'b0;
        tx_repeat = 1'b0;
        tx_addr   = '0;
        tx_cmd    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("rst_ready", tx_ready,   1'b1, i);
            chk("rst_env",   ir_env,     1'b0, i);
            chk("rst_out",   ir_out,     1'b0, i);
            chk("rst_done",  frame_done, 1'b0, i);
        end

        run(8'h00, 8'h30, 1, PER + 1, 1'b1);

        for (int i = 0; i < 3; i++)
            run(8'($urandom), 8'($urandom), 1, PER + 1, 1'b0);

        run(8'($urandom), 8'($urandom), 1, 150, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", tx_ready,   1'b1, 151);
        chk("mid_rst_env",   ir_env,     1'b0, 151);
        chk("mid_rst_out",   ir_out,     1'b0, 151);
        chk("mid_rst_done",  frame_done, 1'b0, 151);
        rst = 1'b0;
        run(8'($urandom), 8'($urandom), 1, PER + 1, 1'b0);

`ifdef NEC_IR_TX_REPEAT_EN
        tx_repeat = 1'b1;
        run(8'($urandom), 8'($urandom), 2, 2 * PER + 1, 1'b0);
        tx_repeat = 1'b0;
`else
        tx_repeat = 1'b1;
        run(8'($urandom), 8'($urandom), 1, PER + 20, 1'b0);
        tx_repeat = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
